fifo_5x16: RTL and testbench

- Instruction prefetch buffer for the IF stage: 5 entries × 16-bit halfwords, filled from a 32-bit-wide instruction SRAM and drained 1 or 2 halfwords per cycle by the decoder (compressed or full instruction).
- Drives the SRAM fetch address and read request; accepts branch redirects from ID.
- Presents the oldest 32 bits as the instruction register.
- Sits between the instruction SRAM (imemory: synchronous read, 1-cycle latency, active-low chip enable driven as ~mem_rq) and the ID stage.

---
 rtl/fifo_5x16.sv | 134 +++++++++++++
 tb/tb_fifo_5x16.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fifo_5x16.sv
// Instruction prefetch buffer: five 16-bit halfword slots filled 32 bits at a time
// from a 1-cycle-latency SRAM, drained 0..2 halfwords per cycle, with branch redirect.
module fifo_5x16 #(
  parameter int          DEPTH    = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_data,
  input  logic [31:0] re_addr,
  input  logic        taken,
  input  logic [1:0]  drain_cnt,
  output logic [31:0] mem_addr,
  output logic        mem_rq,
  output logic [31:0] ir
);

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic [15:0] r_mem [DEPTH];
  logic [2:0]  r_head;
  logic [2:0]  r_count;
  logic [31:0] r_fpc;
  logic        r_pending;
  logic        r_discard;

  logic [2:0]  w_drain_req;
  logic [2:0]  w_drained;
  logic        w_fill;
  logic [3:0]  w_room;
  logic        w_space_ok;
  logic [31:0] w_redir_addr;
  logic [2:0]  w_head_nxt;
  logic [2:0]  w_wr_lo;
  logic [2:0]  w_wr_hi;
  logic [2:0]  w_head_p1;

  // Reduce a small sum into a slot index modulo DEPTH.
  function automatic logic [2:0] wrap_idx(input logic [3:0] idx);
    logic [3:0] t;
    t = idx;
    if (t >= 4'(DEPTH)) begin
      t = t - 4'(DEPTH);
    end else begin
      t = t;
    end
    if (t >= 4'(DEPTH)) begin
      t = t - 4'(DEPTH);
    end else begin
      t = t;
    end
    return t[2:0];
  endfunction

  // Drain clamp, fill qualification, space reservation and slot indices.
  always_comb begin
    w_drain_req  = (drain_cnt == 2'd3) ? 3'd2 : {1'b0, drain_cnt};
    w_drained    = (w_drain_req > r_count) ? r_count : w_drain_req;
    w_fill       = r_pending & ~r_discard;
    // Space for the in-flight response plus the one about to be requested.
    w_room       = {1'b0, r_count} - {1'b0, w_drained}
                 + (w_fill ? 4'd2 : 4'd0) + 4'd2;
    w_space_ok   = (w_room <= 4'(DEPTH));
    w_redir_addr = {re_addr[31:1], 1'b0};
    w_head_nxt   = wrap_idx({1'b0, r_head} + {1'b0, w_drained});
    w_wr_hi      = wrap_idx({1'b0, r_head} + {1'b0, r_count});
    w_wr_lo      = wrap_idx({1'b0, r_head} + {1'b0, r_count} + 4'd1);
    w_head_p1    = wrap_idx({1'b0, r_head} + 4'd1);
  end

  // Fetch address and request; a redirect overrides the sequential fetch pointer.
  always_comb begin
    mem_addr = r_fpc;
    mem_rq   = 1'b0;
    if (!resetn) begin
      mem_addr = r_fpc;
      mem_rq   = 1'b0;
    end else if (taken) begin
      mem_addr = w_redir_addr;
      mem_rq   = 1'b1;
    end else begin
      mem_addr = r_fpc;
      mem_rq   = w_space_ok;
    end
  end

  // Instruction register view of the two oldest stored halfwords.
  always_comb begin
    ir = NOP_INSN;
    case (r_count)
      3'd0:    ir = NOP_INSN;
      3'd1:    ir = {16'h0000, r_mem[r_head]};
      default: ir = {r_mem[w_head_p1], r_mem[r_head]};
    endcase
  end

  // Buffer, pointers and request tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 16'h0000;
      end
      r_head    <= 3'd0;
      r_count   <= 3'd0;
      r_fpc     <= RESET_PC;
      r_pending <= 1'b0;
      r_discard <= 1'b0;
    end else if (taken) begin
      // Flush; whatever response lands this cycle belongs to the old stream.
      r_head    <= 3'd0;
      r_count   <= 3'd0;
      r_fpc     <= w_redir_addr + 32'd4;
      r_pending <= 1'b1;
      r_discard <= 1'b0;
    end else begin
      r_head  <= w_head_nxt;
      r_count <= r_count - w_drained + (w_fill ? 3'd2 : 3'd0);
      if (w_fill) begin
        r_mem[w_wr_hi] <= mem_data[31:16];
        r_mem[w_wr_lo] <= mem_data[15:0];
      end else begin
        r_mem[w_wr_hi] <= r_mem[w_wr_hi];
      end
      r_pending <= w_space_ok;
      r_discard <= r_discard;
      if (w_space_ok) begin
        r_fpc <= r_fpc + 32'd4;
      end else begin
        r_fpc <= r_fpc;
      end
    end
  end

endmodule

// File: tb/tb_fifo_5x16.sv
// Self-checking bench for fifo_5x16: SRAM model plus a halfword-queue reference model.
module tb_fifo_5x16;

  logic        clk;
  logic        resetn;
  logic [31:0] mem_data;
  logic [31:0] re_addr;
  logic        taken;
  logic [1:0]  drain_cnt;
  logic [31:0] mem_addr;
  logic        mem_rq;
  logic [31:0] ir;

  fifo_5x16 #(.DEPTH(5), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .resetn(resetn), .mem_data(mem_data), .re_addr(re_addr),
    .taken(taken), .drain_cnt(drain_cnt), .mem_addr(mem_addr),
    .mem_rq(mem_rq), .ir(ir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] sram [1024];
  logic [15:0] q [$];
  logic        m_pend;
  logic [31:0] m_paddr;
  logic [31:0] m_fpc;
  int          n_assert;
  int          n_fail;

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [9:0] idx;
    idx = a[10:1];
    return sram[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend  = 1'b0;
    m_paddr = 32'h0;
    m_fpc   = 32'h0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input logic tk, input logic [31:0] ra, input logic [1:0] dc);
    int          d;
    int          sz;
    logic        e_rq;
    logic [31:0] e_addr;
    logic [31:0] e_ir;
    logic        s_rq;
    logic [31:0] s_addr;
    taken = tk; re_addr = ra; drain_cnt = dc;
    #1;
    sz = q.size();
    d  = (dc == 2'd3) ? 2 : int'(dc);
    if (d > sz) d = sz;
    if (tk) begin
      e_rq = 1'b1; e_addr = {ra[31:1], 1'b0};
    end else begin
      e_rq = (sz - d + (m_pend ? 2 : 0) + 2) <= 5; e_addr = m_fpc;
    end
    if (sz == 0)      e_ir = 32'h0000_0013;
    else if (sz == 1) e_ir = {16'h0000, q[0]};
    else              e_ir = {q[1], q[0]};
    check("mem_rq", {31'h0, mem_rq}, {31'h0, e_rq});
    check("mem_addr", mem_addr, e_addr);
    check("ir", ir, e_ir);
    s_rq = mem_rq; s_addr = mem_addr;
    @(posedge clk);
    if (tk) begin
      q.delete();
      m_pend = 1'b1; m_paddr = e_addr; m_fpc = e_addr + 32'd4;
    end else begin
      repeat (d) void'(q.pop_front());
      if (m_pend) begin
        q.push_back(hw(m_paddr));
        q.push_back(hw(m_paddr + 32'd2));
      end
      m_pend = e_rq;
      if (e_rq) begin
        m_paddr = m_fpc; m_fpc = m_fpc + 32'd4;
      end
    end
    #1;
    mem_data = s_rq ? {hw(s_addr), hw(s_addr + 32'd2)} : $urandom;
    @(negedge clk);
  endtask

  logic [31:0] insns [6];
  logic [1:0]  mix_drains [8];
  logic [31:0] w;

  initial begin
    n_assert = 0; n_fail = 0;
    insns[0] = 32'h00A0_0093; insns[1] = 32'h0010_0113; insns[2] = 32'h0020_0193;
    insns[3] = 32'h0030_0213; insns[4] = 32'h0040_0293; insns[5] = 32'h0050_0313;
    mix_drains[0] = 2'd1; mix_drains[1] = 2'd2; mix_drains[2] = 2'd1; mix_drains[3] = 2'd2;
    mix_drains[4] = 2'd1; mix_drains[5] = 2'd2; mix_drains[6] = 2'd1; mix_drains[7] = 2'd2;
    for (int i = 0; i < 1024; i++) sram[i] = 16'($urandom);
    for (int i = 0; i < 6; i++) begin
      w = insns[i];
      sram[2*i]   = w[15:0];
      sram[2*i+1] = w[31:16];
    end
    sram[10'h20] = 16'h4501; sram[10'h21] = 16'h0113;
    sram[10'h22] = 16'h0010; sram[10'h23] = 16'h4585;
    sram[10'h80] = 16'h5678; sram[10'h81] = 16'h1234; sram[10'h82] = 16'hBEEF;

    // Reset and fill with no draining.
    resetn = 1'b0; taken = 1'b0; re_addr = 32'h0; drain_cnt = 2'd0; mem_data = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rq", {31'h0, mem_rq}, 32'h0);
    check("reset_ir", ir, 32'h0000_0013);
    resetn = 1'b1;
    repeat (6) step(1'b0, 32'h0, 2'd0);
    check("full_rq", {31'h0, mem_rq}, 32'h0);
    check("full_addr", mem_addr, 32'h0000_0008);
    check("full_ir", ir, insns[0]);

    // Steady two-halfword drain.
    for (int k = 1; k < 6; k++) begin
      step(1'b0, 32'h0, 2'd2);
      check("stream_ir", ir, insns[k]);
    end

    // Mixed compressed/full stream, wrapping head.
    step(1'b1, 32'h0000_0040, 2'd0);
    step(1'b0, 32'h0, 2'd0);
    check("mix_ir", ir, 32'h0113_4501);
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, mix_drains[k]);

    // Redirect with a request in flight.
    repeat (4) step(1'b0, 32'h0, 2'd2);
    step(1'b1, 32'h0000_0100, 2'd0);
    step(1'b0, 32'h0, 2'd0);
    check("redir_ir", ir, 32'h1234_5678);
    step(1'b0, 32'h0, 2'd2);

    // Redirect to a halfword-odd address.
    step(1'b1, 32'h0000_0102, 2'd0);
    step(1'b0, 32'h0, 2'd0);
    check("odd_ir", ir, 32'hBEEF_1234);
    repeat (3) step(1'b0, 32'h0, 2'd1);

    // Asynchronous reset mid-stream.
    #2 resetn = 1'b0;
    #1;
    check("async_rq", {31'h0, mem_rq}, 32'h0);
    check("async_ir", ir, 32'h0000_0013);
    model_reset();
    repeat (2) @(negedge clk);
    taken = 1'b0; drain_cnt = 2'd0;
    resetn = 1'b1;
    step(1'b0, 32'h0, 2'd0);
    step(1'b0, 32'h0, 2'd0);

    // Random drains and redirects.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(9) == 0)
        step(1'b1, $urandom & 32'h0000_07FE, 2'($urandom_range(3)));
      else
        step(1'b0, 32'h0, 2'($urandom_range(3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
